// File: rtl/eda_local_max_scan.sv
// eda_local_max_scan: raster-scan address generator with 3x3 local-maximum classifier and one-entry output buffer
module eda_local_max_scan #(
  parameter int M            = 8,
  parameter int N            = 8,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int I_WIDTH      = 3,
  parameter int J_WIDTH      = 3,
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH-1:0]               out_addr,
  output logic                                out_is_max,
  output logic                                out_has_equal,
  output logic                                busy,
  output logic                                done
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam int C = WINDOW_WIDTH / 2;
  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   center_q, center_d, out_addr_q;
  logic                    out_valid_q, out_is_max_q, out_has_equal_q, busy_q, done_q;
  logic [PIXEL_WIDTH-1:0]  ctr;
  logic [WINDOW_WIDTH-2:0] ge, eq;
  logic [I_WIDTH-1:0]      ci;
  logic [J_WIDTH-1:0]      cj;
  logic                    is_max, has_eq, adv, last_j, last;
  assign ctr = window_values[C*PIXEL_WIDTH +: PIXEL_WIDTH];
  // neighbour bit k maps to window slice k below the center and k+1 above it
  for (genvar k = 0; k < WINDOW_WIDTH - 1; k++) begin : g_nb
    localparam int S = (k < C) ? k : k + 1;
    assign ge[k] = ctr >= window_values[S*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign eq[k] = ctr == window_values[S*PIXEL_WIDTH +: PIXEL_WIDTH];
  end
  // out-of-image neighbours are masked out: they can neither defeat the max nor count as equal
  assign is_max   = &(ge | ~neigh_addr_valid);
  assign has_eq   = is_max & |(eq & neigh_addr_valid);
  assign ci       = center_q[ADDR_WIDTH-1 -: I_WIDTH];
  assign cj       = center_q[J_WIDTH-1:0];
  assign last_j   = cj == J_WIDTH'(N - 1);
  assign last     = last_j && ci == I_WIDTH'(M - 1);
  assign center_d = last_j ? {ci + I_WIDTH'(1), J_WIDTH'(0)} : {ci, cj + J_WIDTH'(1)};
  assign adv      = !out_valid_q || out_ready;
  // scan FSM: steps the center address and fills the output buffer whenever it is free or being drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      center_q        <= '0;
      out_valid_q     <= 1'b0;
      out_addr_q      <= '0;
      out_is_max_q    <= 1'b0;
      out_has_equal_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q  <= SCAN;
          center_q <= '0;
          busy_q   <= 1'b1;
        end
        SCAN: if (adv) begin
          out_valid_q     <= 1'b1;
          out_addr_q      <= center_q;
          out_is_max_q    <= is_max;
          out_has_equal_q <= has_eq;
          if (last) state_q <= DRAIN;
          else center_q <= center_d;
        end
        DRAIN: if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign center_addr   = center_q;
  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_is_max    = out_is_max_q;
  assign out_has_equal = out_has_equal_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_eda_local_max_scan.sv
// tb_eda_local_max_scan: image-level model checks of an 8x8 and a 3x5 scanner
module tb_eda_local_max_scan;
  typedef logic [7:0] img_t [8][8];
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic rnd_ready = 1'b1, bp_hold = 1'b0, fix9 = 1'b0;
  logic [7:0] fill_r = 8'd0;
  int rmode = 0;
  logic or_a;
  logic [5:0] ca_a, oa_a;
  logic [4:0] ca_b, oa_b;
  logic [71:0] win_a, win_b;
  logic [7:0] msk_a, msk_b;
  logic ov_a, im_a, he_a, busy_a, done_a, ov_b, im_b, he_b, busy_b, done_b;
  img_t img_a, img_b;
  int checks = 0, passed = 0, cyc = 0;
  int hs_a = 0, base_a = 0, done_cnt_a = 0, done_cyc_a = 0, last_hs_a = 0, busy_cnt_a = 0, d0_a = 0, b0_a = 0;
  int hs_b = 0, base_b = 0, done_cnt_b = 0, done_cyc_b = 0, last_hs_b = 0, d0_b = 0;
  bit armed_a = 1'b0, armed_b = 1'b0;
  logic [1:0] dut_res [64];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: actual %0h required %0h", n, a, e);
  endtask

  task automatic fail_unexpected(input string n, input logic [31:0] a);
    checks++;
    $display("FAIL %s: actual result at addr %0h, required no result", n, a);
  endtask

  // {is_max, has_equal} straight from the image: compare the pixel with its in-image neighbours
  function automatic logic [1:0] classify(input img_t im, input int i, input int j, input int m, input int n);
    logic mx, eq;
    mx = 1'b1;
    eq = 1'b0;
    for (int di = -1; di <= 1; di++)
      for (int dj = -1; dj <= 1; dj++)
        if ((di != 0 || dj != 0) && i + di >= 0 && i + di < m && j + dj >= 0 && j + dj < n) begin
          if (im[i+di][j+dj] > im[i][j]) mx = 1'b0;
          if (im[i+di][j+dj] == im[i][j]) eq = 1'b1;
        end
    return {mx, mx & eq};
  endfunction

  // RAM window port: 3x3 slices MSB-first, out-of-image slices filled with junk value f
  function automatic logic [79:0] window(input img_t im, input int i, input int j, input int m, input int n, input logic [7:0] f);
    logic [71:0] v;
    logic [7:0] mk;
    int s, r, c;
    bit in_img;
    s = 8;
    v = '0;
    mk = '0;
    for (int di = -1; di <= 1; di++)
      for (int dj = -1; dj <= 1; dj++) begin
        r = i + di;
        c = j + dj;
        in_img = r >= 0 && r < m && c >= 0 && c < n;
        if (di == 0 && dj == 0) v[s*8 +: 8] = im[i][j];
        else begin
          v[s*8 +: 8] = in_img ? im[r][c] : f;
          mk[s > 4 ? s - 1 : s] = in_img;
        end
        s--;
      end
    return {v, mk};
  endfunction

  assign or_a = (rmode == 1) ? rnd_ready : !bp_hold;
  assign {win_a, msk_a} = window(img_a, int'(ca_a[5:3]), int'(ca_a[2:0]), 8, 8, fix9 ? 8'd9 : fill_r);
  assign {win_b, msk_b} = window(img_b, int'(ca_b[4:3]), int'(ca_b[2:0]), 3, 5, fill_r);

  eda_local_max_scan dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .center_addr(ca_a),
    .window_values(win_a), .neigh_addr_valid(msk_a), .out_valid(ov_a), .out_ready(or_a),
    .out_addr(oa_a), .out_is_max(im_a), .out_has_equal(he_a), .busy(busy_a), .done(done_a));

  eda_local_max_scan #(.M(3), .N(5), .I_WIDTH(2), .J_WIDTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .center_addr(ca_b),
    .window_values(win_b), .neigh_addr_valid(msk_b), .out_valid(ov_b), .out_ready(1'b1),
    .out_addr(oa_b), .out_is_max(im_b), .out_has_equal(he_b), .busy(busy_b), .done(done_b));

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    rnd_ready = $urandom_range(0, 3) != 0;
    fill_r = 8'($urandom);
  end

  // k-th accepted result must be raster pixel k of the current image
  always @(negedge clk) begin : mon_a
    int k;
    if (ov_a && or_a) begin
      k = hs_a - base_a;
      if (!armed_a || k >= 64) fail_unexpected("a_unexpected_result", 32'(oa_a));
      else chk("a_result", {oa_a, im_a, he_a}, {k[5:0], classify(img_a, k / 8, k % 8, 8, 8)});
      dut_res[oa_a] = {im_a, he_a};
      hs_a++;
      last_hs_a = cyc;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (busy_a) busy_cnt_a++;
  end

  always @(negedge clk) begin : mon_b
    int k, i, j;
    if (busy_b) chk("b_j_in_range", 32'(ca_b[2:0] < 3'd5), 1);
    if (ov_b) begin
      k = hs_b - base_b;
      i = k / 5;
      j = k % 5;
      if (!armed_b || k >= 15) fail_unexpected("b_unexpected_result", 32'(oa_b));
      else chk("b_result", {oa_b, im_b, he_b}, {i[1:0], j[2:0], classify(img_b, i, j, 3, 5)});
      hs_b++;
      last_hs_b = cyc;
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic start_scan_a(input int rm);
    rmode = rm;
    bp_hold = 1'b0;
    base_a = hs_a;
    d0_a = done_cnt_a;
    b0_a = busy_cnt_a;
    armed_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic finish_scan_a(input int rm);
    for (int k = 0; k < 3000 && done_cnt_a == d0_a; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("a_result_count", hs_a - base_a, 64);
    chk("a_done_pulses", done_cnt_a - d0_a, 1);
    chk("a_done_after_last_handshake", done_cyc_a - last_hs_a, 1);
    if (rm == 0) chk("a_busy_cycles", busy_cnt_a - b0_a, 65);
    armed_a = 1'b0;
  endtask

  task automatic random_img_a();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img_a[r][c] = 8'($urandom_range(0, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img_a[r][c] = 8'd0;
        img_b[r][c] = 8'd0;
      end
    #12;
    chk("rst_center_addr", ca_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_addr", oa_a, 0);
    chk("rst_out_is_max", im_a, 0);
    chk("rst_out_has_equal", he_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    reset_n = 1'b1;
    // all-zero image: every pixel is a max with an equal neighbour
    start_scan_a(0);
    finish_scan_a(0);
    chk("zero_first", dut_res[0], 2'b11);
    chk("zero_last", dut_res[63], 2'b11);
    // single bright pixel among 10s
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img_a[r][c] = 8'd10;
    img_a[3][5] = 8'd200;
    chk("model_peak", classify(img_a, 3, 5, 8, 8), 2'b10);
    chk("model_peak_neighbour", classify(img_a, 2, 4, 8, 8), 2'b00);
    chk("model_flat", classify(img_a, 7, 0, 8, 8), 2'b11);
    chk("model_single_pixel", classify(img_a, 0, 0, 1, 1), 2'b10);
    start_scan_a(0);
    finish_scan_a(0);
    chk("peak_dut", dut_res[29], 2'b10);
    chk("peak_nb_up_left", dut_res[20], 2'b00);
    chk("peak_nb_down_right", dut_res[38], 2'b00);
    chk("peak_distant", dut_res[0], 2'b11);
    // corner with junk 9s in the out-of-image slices
    random_img_a();
    img_a[0][0] = 8'd5;
    img_a[0][1] = 8'd4;
    img_a[1][0] = 8'd4;
    img_a[1][1] = 8'd4;
    fix9 = 1'b1;
    chk("model_corner", classify(img_a, 0, 0, 8, 8), 2'b10);
    start_scan_a(1);
    finish_scan_a(1);
    chk("corner_dut", dut_res[0], 2'b10);
    fix9 = 1'b0;
    // random images, random backpressure, one with start pulsed mid-scan
    for (int t = 0; t < 3; t++) begin
      random_img_a();
      start_scan_a(1);
      if (t == 1) begin
        repeat (10) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
      end
      finish_scan_a(1);
    end
    // hold result 6 for three cycles
    random_img_a();
    start_scan_a(2);
    for (int k = 0; k < 500 && hs_a - base_a < 6; k++) @(posedge clk);
    #1 bp_hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("bp_valid", ov_a, 1);
      chk("bp_out_addr", oa_a, 6);
      chk("bp_out_is_max", im_a, 32'(classify(img_a, 0, 6, 8, 8) >> 1));
      chk("bp_center_addr", ca_a, 7);
      if (h == 1) begin
        @(posedge clk);
        #1 bp_hold = 1'b0;
      end
    end
    finish_scan_a(2);
    // reset mid-scan
    random_img_a();
    start_scan_a(0);
    for (int k = 0; k < 500 && hs_a - base_a < 20; k++) @(posedge clk);
    #2 reset_n = 1'b0;
    armed_a = 1'b0;
    #1;
    chk("midrst_out_valid", ov_a, 0);
    chk("midrst_center_addr", ca_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_out_addr", oa_a, 0);
    #4 reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_idle", ov_a, 0);
    end
    random_img_a();
    start_scan_a(0);
    finish_scan_a(0);
    // 3x5 non-power-of-two image
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 5; c++) img_b[r][c] = 8'($urandom_range(0, 3));
      base_b = hs_b;
      d0_b = done_cnt_b;
      armed_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int k = 0; k < 500 && done_cnt_b == d0_b; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("b_result_count", hs_b - base_b, 15);
      chk("b_done_pulses", done_cnt_b - d0_b, 1);
      chk("b_done_after_last_handshake", done_cyc_b - last_hs_b, 1);
      armed_b = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
